pixel_pack: RTL and testbench
=============================

PIXEL_PACK -- requirements
Module: pixel_pack

Interface
REQ-001 The module SHALL have a parameter C_PORT_NUM, default 2, giving the number of pixel ports per beat (range 1..4).
REQ-002 The module SHALL have a parameter C_BPC, default 8, giving bits per component; only the value 8 is supported.
REQ-003 The module SHALL have one clock and a synchronous active-high reset: CLK_I  in  1  clock; RST_I  in  1  synchronous active-high reset.
REQ-004 The module SHALL have OSPACE_I  in  2  stream colour space (0 RGB, 1 YUV444, 2 YUV422, 3 YUV420).
REQ-005 The module SHALL have ACTUAL_PORT_NUM_I  in  3  number of active ports.
REQ-006 The module SHALL have PIXEL_VS_I, PIXEL_HS_I, PIXEL_DE_I  in  1 each  video timing from the colour-space converter.
REQ-007 The module SHALL have PIXEL_DATA_I  in  C_PORT_NUM*24  pixel data, with port 0 in bits [23:0].
REQ-008 The module SHALL have WR_DATA_O  out  64  packed word; WR_VALID_O  out  1; WR_READY_I  in  1; WR_LAST_O  out  1  last word of line.
REQ-009 The module SHALL have FRAME_START_O  out  1  one-cycle pulse; OVERFLOW_O  out  1  sticky overflow flag.

Function
REQ-010 The module SHALL latch OSPACE_I and ACTUAL_PORT_NUM_I on each PIXEL_VS_I rising edge; a value of 0 or >C_PORT_NUM SHALL be treated as C_PORT_NUM.
REQ-011 The bytes per port SHALL be 2 for OSPACE 2 (bits [15:0] of the slot) and 3 otherwise (bits [23:0]).
REQ-012 On each cycle with PIXEL_DE_I=1 in state LINE, the module SHALL append N = ports*bytes bytes, port 0 first, to a 16-byte buffer with byte count CNT (0..16).
REQ-013 The buffer SHALL be ordered so that the oldest byte maps to WR_DATA_O[7:0].
REQ-014 WR_VALID_O SHALL assert the cycle after CNT>=8 and present the oldest 8 bytes.
REQ-015 WR_DATA_O, WR_VALID_O and WR_LAST_O SHALL be held stable while WR_VALID_O=1 and WR_READY_I=0.
REQ-016 A word SHALL be consumed when WR_VALID_O and WR_READY_I are both 1; an append and a consume in the same cycle SHALL both take effect, giving CNT = CNT - 8 + N.
REQ-017 If an append would make CNT exceed 16, the whole beat SHALL be dropped and OVERFLOW_O set; OVERFLOW_O SHALL clear only on PIXEL_VS_I rising or reset.
REQ-018 The state machine SHALL have states IDLE, LINE and FLUSH.
REQ-019 A PIXEL_VS_I rising edge SHALL take IDLE to LINE; from any state it SHALL pulse FRAME_START_O, clear CNT, abort any pending word (WR_VALID_O=0 next cycle) and enter LINE.
REQ-020 In LINE, a PIXEL_DE_I falling edge SHALL take the machine to FLUSH (macro enabled) or leave it in LINE (macro disabled).
REQ-021 In FLUSH, all full words SHALL drain first; a remaining partial word (0<CNT<8) SHALL then be emitted zero-padded in its upper lanes.
REQ-022 The final word of a line SHALL carry WR_LAST_O=1; FLUSH SHALL then return to LINE when CNT=0.
REQ-023 When CNT is an exact multiple of 8 at the DE falling edge, the last full word SHALL carry WR_LAST_O=1 and no padding word SHALL be emitted.
REQ-024 A DE falling edge with CNT=0 SHALL return to LINE with no output.
REQ-025 A beat with PIXEL_DE_I=1 during FLUSH SHALL be dropped and SHALL set OVERFLOW_O.
REQ-026 PIXEL_HS_I SHALL be ignored for packing.

Reset
REQ-027 On RST_I=1 at a clock edge, the module SHALL set state=IDLE, CNT=0, WR_DATA_O=0, WR_VALID_O=0, WR_LAST_O=0, FRAME_START_O=0 and OVERFLOW_O=0.
REQ-028 On reset, the latched configuration SHALL become OSPACE=0 and ports=C_PORT_NUM.
REQ-029 Reset mid-line SHALL discard buffered bytes, and the module SHALL await the next PIXEL_VS_I rising edge.

Configuration
REQ-030 The macro PIXEL_PACK_LINE_FLUSH_EN SHALL control line flushing. When defined, FLUSH and WR_LAST_O operate per REQ-020..REQ-025. When undefined, FLUSH is absent, WR_LAST_O is tied 0, and leftover bytes carry into the next line; only PIXEL_VS_I discards them.

Verification
REQ-031 RGB, ports=1, C_PORT_NUM=2: 8 DE beats carrying bytes 0x01..0x18 -> three words, the first being 64'h0807060504030201, and WR_LAST_O=1 on the third.
REQ-032 YUV422, ports=2: 3 beats (12 bytes) then DE low -> word 1 full; word 2 = 64'h000000000C0B0A09 with WR_LAST_O=1 (macro on), or word 2 held until the next line (macro off).
REQ-033 RGB, ports=2, WR_READY_I=0 for 4 beats -> the 3rd beat is dropped (CNT would reach 18), OVERFLOW_O=1, and WR_DATA_O stays stable.
REQ-034 PIXEL_VS_I rising edge while WR_VALID_O=1 -> FRAME_START_O pulses for 1 cycle, WR_VALID_O=0 next cycle, OVERFLOW_O cleared and CNT=0.
REQ-035 RST_I asserted mid-line with CNT=5 -> all outputs 0 next cycle, and DE beats are ignored until PIXEL_VS_I rises.
REQ-036 ACTUAL_PORT_NUM_I=0 latched at VS -> packing uses C_PORT_NUM ports (6 bytes per beat in RGB).

Source files
------------

// File: rtl/pixel_pack.sv
// pixel_pack: packs per-beat pixel bytes from a colour-space converter into 64-bit words for a
// downstream write channel.
//
// Each PIXEL_DE_I beat contributes ports*bytes bytes (3 per port, 2 per port for YUV422), port 0
// first, into a 16-byte FIFO-like buffer whose oldest byte maps to WR_DATA_O[7:0]. Words leave
// through a valid/ready handshake; a beat that does not fit is dropped and OVERFLOW_O sticks
// until the next frame. Colour space and active port count are latched on each PIXEL_VS_I rise.
//
// Optional feature macro: PIXEL_PACK_LINE_FLUSH_EN
//   defined   - a DE falling edge flushes the line: full words drain, a partial remainder goes
//               out zero-padded, and the final word of the line carries WR_LAST_O.
//   undefined - no flushing, WR_LAST_O tied 0, leftover bytes carry into the next line.
//
// Ports
//   CLK_I, RST_I          clock, synchronous active-high reset
//   OSPACE_I              colour space (0 RGB, 1 YUV444, 2 YUV422, 3 YUV420)
//   ACTUAL_PORT_NUM_I     active ports (0 or > C_PORT_NUM means C_PORT_NUM)
//   PIXEL_VS/HS/DE_I      video timing (HS unused)
//   PIXEL_DATA_I          C_PORT_NUM x 24-bit pixel slots, port 0 in [23:0]
//   WR_DATA_O/VALID_O     packed word and valid, WR_READY_I back-pressure
//   WR_LAST_O             last word of a line
//   FRAME_START_O         one-cycle pulse per VS rise
//   OVERFLOW_O            sticky dropped-beat flag
module pixel_pack #(
  parameter int unsigned C_PORT_NUM = 2,
  parameter int unsigned C_BPC      = 8
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic [1:0]               OSPACE_I,
  input  logic [2:0]               ACTUAL_PORT_NUM_I,
  input  logic                     PIXEL_VS_I,
  input  logic                     PIXEL_HS_I,
  input  logic                     PIXEL_DE_I,
  input  logic [C_PORT_NUM*24-1:0] PIXEL_DATA_I,
  output logic [63:0]              WR_DATA_O,
  output logic                     WR_VALID_O,
  input  logic                     WR_READY_I,
  output logic                     WR_LAST_O,
  output logic                     FRAME_START_O,
  output logic                     OVERFLOW_O
);

  localparam int unsigned ByteW = C_BPC;
  localparam int unsigned BeatW = C_PORT_NUM * 24;

  typedef enum logic [1:0] {StIdle, StLine, StFlush} state_e;

  state_e       state_q;
  logic [127:0] buf_q;
  logic [4:0]   cnt_q;
  logic [1:0]   ospace_q;
  logic [2:0]   ports_q;
  logic         vs_q;
  logic         valid_q;
  logic [63:0]  data_q;
  logic         frame_q;
  logic         ovf_q;

  logic             vs_rise;
  logic             bpp3;
  logic [2:0]       ports_eff;
  logic [BeatW-1:0] beat_bytes;
  logic [4:0]       n_bytes;
  logic             consume;
  logic             stall;
  logic [4:0]       take;
  logic [4:0]       cnt_base;
  logic [4:0]       cnt_sum;
  logic [4:0]       cnt_nxt;
  logic [127:0]     buf_base;
  logic [127:0]     buf_nxt;
  logic             beat_fits;
  logic             append_ok;
  logic             beat_drop;
  logic             valid_nxt;

  // Horizontal sync carries no information the packer needs.
  logic unused_hs;
  assign unused_hs = PIXEL_HS_I;

  assign vs_rise   = PIXEL_VS_I & ~vs_q;
  assign bpp3      = (ospace_q != 2'd2);
  assign ports_eff = (ACTUAL_PORT_NUM_I == 3'd0 || 32'(ACTUAL_PORT_NUM_I) > C_PORT_NUM) ?
                     3'(C_PORT_NUM) : ACTUAL_PORT_NUM_I;

  // Compact the active slots into contiguous bytes; inactive lanes stay zero so the buffer
  // above CNT is always zero, which gives padding of a partial word for free.
  always_comb begin
    beat_bytes = '0;
    for (int unsigned p = 0; p < C_PORT_NUM; p++) begin
      if (p < 32'(ports_q)) begin
        if (bpp3) beat_bytes[p*24 +: 3*ByteW] = PIXEL_DATA_I[p*24 +: 3*ByteW];
        else      beat_bytes[p*16 +: 2*ByteW] = PIXEL_DATA_I[p*24 +: 2*ByteW];
      end
    end
  end

  assign n_bytes   = bpp3 ? 5'(ports_q) * 5'd3 : {1'b0, ports_q, 1'b0};
  assign consume   = valid_q & WR_READY_I;
  assign stall     = valid_q & ~WR_READY_I;
  // A flushed partial word removes fewer than 8 bytes.
  assign take      = !consume ? 5'd0 : ((cnt_q >= 5'd8) ? 5'd8 : cnt_q);
  assign cnt_base  = cnt_q - take;
  assign buf_base  = consume ? (buf_q >> 64) : buf_q;
  assign cnt_sum   = cnt_base + n_bytes;
  assign beat_fits = (cnt_sum <= 5'd16);
  assign append_ok = (state_q == StLine) && PIXEL_DE_I && beat_fits;
  assign beat_drop = PIXEL_DE_I && ((state_q == StFlush) || (state_q == StLine && !beat_fits));
  assign cnt_nxt   = append_ok ? cnt_sum : cnt_base;
  assign buf_nxt   = append_ok ? (buf_base | (128'(beat_bytes) << {cnt_base, 3'b000})) : buf_base;

`ifdef PIXEL_PACK_LINE_FLUSH_EN
  logic de_q;
  logic de_fall;
  logic flushing;
  logic last_q;
  logic last_nxt;

  assign de_fall  = ~PIXEL_DE_I & de_q;
  assign flushing = (state_q == StFlush) || (state_q == StLine && de_fall);

  // While the line is running, a word is only offered once more bytes exist behind it: with
  // exactly 8 buffered we cannot yet tell whether it is the last word of the line, and its
  // WR_LAST_O may not change once it is on the bus.
  always_comb begin
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    if (flushing) begin
      valid_nxt = (cnt_nxt != 5'd0);
      last_nxt  = (cnt_nxt != 5'd0) && (cnt_nxt <= 5'd8);
    end else begin
      valid_nxt = (cnt_nxt > 5'd8);
    end
  end

  always_ff @(posedge CLK_I) begin
    de_q <= PIXEL_DE_I;
  end

  assign WR_LAST_O = last_q;
`else
  always_comb begin
    valid_nxt = (cnt_nxt >= 5'd8);
  end

  assign WR_LAST_O = 1'b0;
`endif

  always_ff @(posedge CLK_I) begin
    // Edge detector tracks VS even in reset so a level held high across reset is not an edge.
    vs_q <= PIXEL_VS_I;
    if (RST_I) begin
      state_q  <= StIdle;
      buf_q    <= '0;
      cnt_q    <= '0;
      ospace_q <= 2'd0;
      ports_q  <= 3'(C_PORT_NUM);
      valid_q  <= 1'b0;
      data_q   <= '0;
      frame_q  <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef PIXEL_PACK_LINE_FLUSH_EN
      last_q   <= 1'b0;
`endif
    end else begin
      frame_q <= 1'b0;
      if (vs_rise) begin
        // New frame from any state: drop everything buffered, including a stalled word.
        state_q  <= StLine;
        buf_q    <= '0;
        cnt_q    <= '0;
        ospace_q <= OSPACE_I;
        ports_q  <= ports_eff;
        valid_q  <= 1'b0;
        data_q   <= '0;
        frame_q  <= 1'b1;
        ovf_q    <= 1'b0;
`ifdef PIXEL_PACK_LINE_FLUSH_EN
        last_q   <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StLine, StFlush: begin
            cnt_q <= cnt_nxt;
            buf_q <= buf_nxt;
            if (beat_drop) ovf_q <= 1'b1;
            if (!stall) begin
              valid_q <= valid_nxt;
              data_q  <= valid_nxt ? buf_nxt[63:0] : 64'd0;
`ifdef PIXEL_PACK_LINE_FLUSH_EN
              last_q  <= last_nxt;
`endif
            end
`ifdef PIXEL_PACK_LINE_FLUSH_EN
            if (state_q == StLine && de_fall && cnt_nxt != 5'd0) begin
              state_q <= StFlush;
            end else if (state_q == StFlush && cnt_nxt == 5'd0) begin
              state_q <= StLine;
            end
`endif
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign WR_DATA_O     = data_q;
  assign WR_VALID_O    = valid_q;
  assign FRAME_START_O = frame_q;
  assign OVERFLOW_O    = ovf_q;

endmodule

// File: tb/tb_pixel_pack.sv
// Directed bench for pixel_pack (C_PORT_NUM=2). Accepted words are captured into a queue and
// compared against hand-computed constants; expectations follow the line-flush macro setting.
module tb_pixel_pack;

`ifdef PIXEL_PACK_LINE_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ospace;
  logic [2:0]  act;
  logic        vs;
  logic        hs;
  logic        de;
  logic [47:0] pdata;
  logic [63:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_last;
  logic        frame_start;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [64:0] mon_q[$];

  always #5 clk = ~clk;

  pixel_pack #(
    .C_PORT_NUM(2),
    .C_BPC     (8)
  ) u_dut (
    .CLK_I            (clk),
    .RST_I            (rst),
    .OSPACE_I         (ospace),
    .ACTUAL_PORT_NUM_I(act),
    .PIXEL_VS_I       (vs),
    .PIXEL_HS_I       (hs),
    .PIXEL_DE_I       (de),
    .PIXEL_DATA_I     (pdata),
    .WR_DATA_O        (wr_data),
    .WR_VALID_O       (wr_valid),
    .WR_READY_I       (wr_ready),
    .WR_LAST_O        (wr_last),
    .FRAME_START_O    (frame_start),
    .OVERFLOW_O       (overflow)
  );

  // Capture every accepted word as {last, data}.
  always @(negedge clk) begin
    if (wr_valid === 1'b1 && wr_ready === 1'b1) mon_q.push_back({wr_last, wr_data});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    de = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic beat(input logic [47:0] d);
    de    = 1'b1;
    pdata = d;
    step();
  endtask

  task automatic frame(input string tag, input logic [1:0] os, input logic [2:0] ap);
    ospace = os;
    act    = ap;
    de     = 1'b0;
    vs     = 1'b1;
    step();
    check_eq({tag, "_fs_pulse"}, 64'(frame_start), 64'd1);
    vs = 1'b0;
    step();
    check_eq({tag, "_fs_end"}, 64'(frame_start), 64'd0);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [63:0] exp_data,
                            input logic exp_last);
    logic [64:0] w;
    w = {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    if (idx < mon_q.size()) w = mon_q[idx];
    check_eq({tag, "_data"}, w[63:0], exp_data);
    check_eq({tag, "_last"}, 64'(w[64]), 64'(exp_last));
  endtask

  // Port 0 carries s, s+1, s+2; port 1 holds filler that must not be packed.
  function automatic logic [47:0] rgb1(input logic [7:0] s);
    return {24'hA5C3E1, s + 8'd2, s + 8'd1, s};
  endfunction

  function automatic logic [47:0] rgb2(input logic [7:0] s);
    return {s + 8'd5, s + 8'd4, s + 8'd3, s + 8'd2, s + 8'd1, s};
  endfunction

  // YUV422: only the low 16 bits of each slot are packed.
  function automatic logic [47:0] yuv2(input logic [7:0] s);
    return {8'hEE, s + 8'd3, s + 8'd2, 8'hEE, s + 8'd1, s};
  endfunction

  initial begin
    rst = 1'b1; vs = 1'b0; hs = 1'b0; de = 1'b0; pdata = '0;
    ospace = 2'd0; act = 3'd0; wr_ready = 1'b1;
    step();
    step();
    check_eq("rst_valid", 64'(wr_valid), 64'd0);
    check_eq("rst_data", wr_data, 64'd0);
    check_eq("rst_last", 64'(wr_last), 64'd0);
    check_eq("rst_fs", 64'(frame_start), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    step();

    // RGB, one port, 24 bytes -> three words.
    frame("t1", 2'd0, 3'd1);
    mon_q.delete();
    for (int k = 0; k < 8; k++) begin
      hs = k[0];
      beat(rgb1(8'(1 + 3 * k)));
    end
    hs = 1'b0;
    idle(4);
    check_eq("t1_words", 64'(mon_q.size()), 64'd3);
    check_word("t1_w0", 0, 64'h0807060504030201, 1'b0);
    check_word("t1_w1", 1, 64'h100F0E0D0C0B0A09, 1'b0);
    check_word("t1_w2", 2, 64'h1817161514131211, FlushEn);

    // YUV422, two ports, 12 bytes then DE low.
    frame("t2", 2'd2, 3'd2);
    mon_q.delete();
    beat(yuv2(8'h01));
    beat(yuv2(8'h05));
    beat(yuv2(8'h09));
    idle(4);
`ifdef PIXEL_PACK_LINE_FLUSH_EN
    check_eq("t2_words", 64'(mon_q.size()), 64'd2);
    check_word("t2_w0", 0, 64'h0807060504030201, 1'b0);
    check_word("t2_w1", 1, 64'h000000000C0B0A09, 1'b1);
`else
    check_eq("t2_words", 64'(mon_q.size()), 64'd1);
    check_word("t2_w0", 0, 64'h0807060504030201, 1'b0);
    beat(yuv2(8'h0D));
    idle(3);
    check_eq("t2_carry_words", 64'(mon_q.size()), 64'd2);
    check_word("t2_w1", 1, 64'h100F0E0D0C0B0A09, 1'b0);
`endif

    // RGB, two ports, stalled sink: third and fourth beats overflow.
    frame("t3", 2'd0, 3'd2);
    mon_q.delete();
    wr_ready = 1'b0;
    beat(rgb2(8'h01));
    check_eq("t3_b0_valid", 64'(wr_valid), 64'd0);
    check_eq("t3_b0_ovf", 64'(overflow), 64'd0);
    beat(rgb2(8'h07));
    check_eq("t3_b1_valid", 64'(wr_valid), 64'd1);
    check_eq("t3_b1_data", wr_data, 64'h0807060504030201);
    beat(rgb2(8'h0D));
    check_eq("t3_b2_ovf", 64'(overflow), 64'd1);
    check_eq("t3_b2_data", wr_data, 64'h0807060504030201);
    beat(rgb2(8'h13));
    check_eq("t3_b3_valid", 64'(wr_valid), 64'd1);
    check_eq("t3_b3_data", wr_data, 64'h0807060504030201);
    idle(2);
    check_eq("t3_hold_data", wr_data, 64'h0807060504030201);
    wr_ready = 1'b1;
    idle(4);
    check_eq("t3_ovf_sticky", 64'(overflow), 64'd1);
    check_eq("t3_words", 64'(mon_q.size()), FlushEn ? 64'd2 : 64'd1);
    check_word("t3_w0", 0, 64'h0807060504030201, 1'b0);
`ifdef PIXEL_PACK_LINE_FLUSH_EN
    check_word("t3_w1", 1, 64'h000000000C0B0A09, 1'b1);
`endif

    // VS rise while a word is pending.
    frame("t4", 2'd0, 3'd2);
    check_eq("t4_ovf_clear", 64'(overflow), 64'd0);
    wr_ready = 1'b0;
    beat(rgb2(8'h41));
    beat(rgb2(8'h47));
    beat(rgb2(8'h4D));
    check_eq("t4_pre_valid", 64'(wr_valid), 64'd1);
    check_eq("t4_pre_ovf", 64'(overflow), 64'd1);
    de = 1'b0;
    vs = 1'b1;
    step();
    check_eq("t4_vs_fs", 64'(frame_start), 64'd1);
    check_eq("t4_vs_valid", 64'(wr_valid), 64'd0);
    check_eq("t4_vs_ovf", 64'(overflow), 64'd0);
    vs = 1'b0;
    step();
    check_eq("t4_fs_end", 64'(frame_start), 64'd0);
    mon_q.delete();
    wr_ready = 1'b1;
    idle(3);
    check_eq("t4_no_words", 64'(mon_q.size()), 64'd0);
    beat(rgb2(8'h21));
    beat(rgb2(8'h27));
    idle(4);
    check_eq("t4_words", 64'(mon_q.size()), FlushEn ? 64'd2 : 64'd1);
    check_word("t4_w0", 0, 64'h2827262524232221, 1'b0);

    // Reset in mid-line with a word on the bus.
    frame("t5", 2'd0, 3'd1);
    for (int k = 0; k < 6; k++) beat(rgb1(8'(1 + 3 * k)));
    check_eq("t5_pre_valid", 64'(wr_valid), 64'd1);
    check_eq("t5_pre_data", wr_data, 64'h100F0E0D0C0B0A09);
    rst   = 1'b1;
    de    = 1'b1;
    pdata = rgb1(8'h13);
    step();
    check_eq("t5_rst_valid", 64'(wr_valid), 64'd0);
    check_eq("t5_rst_data", wr_data, 64'd0);
    check_eq("t5_rst_last", 64'(wr_last), 64'd0);
    check_eq("t5_rst_fs", 64'(frame_start), 64'd0);
    check_eq("t5_rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    mon_q.delete();
    for (int k = 0; k < 4; k++) beat(rgb2(8'(8'h61 + 6 * k)));
    idle(3);
    check_eq("t5_idle_words", 64'(mon_q.size()), 64'd0);
    check_eq("t5_idle_valid", 64'(wr_valid), 64'd0);

    // ACTUAL_PORT_NUM_I of 0 and of 3 both mean two ports.
    frame("t6", 2'd0, 3'd0);
    mon_q.delete();
    beat(rgb2(8'h31));
    beat(rgb2(8'h37));
    idle(4);
    check_eq("t6_words", 64'(mon_q.size()), FlushEn ? 64'd2 : 64'd1);
    check_word("t6_w0", 0, 64'h3837363534333231, 1'b0);

    frame("t7", 2'd0, 3'd3);
    mon_q.delete();
    beat(rgb2(8'h51));
    beat(rgb2(8'h57));
    idle(4);
    check_eq("t7_words", 64'(mon_q.size()), FlushEn ? 64'd2 : 64'd1);
    check_word("t7_w0", 0, 64'h5857565554535251, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
